// File: rtl/moving_average_pkg.sv
// Shared types and sizing helpers for the multi-channel moving-average block.
package moving_average_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PROC = 2'd2
  } state_t;

  function automatic int sum_w_of(input int sample_w, input int log2_win);
    return sample_w + log2_win;
  endfunction

  function automatic int window_of(input int log2_win);
    return 1 << log2_win;
  endfunction

  function automatic int half_depth_of(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

  // Half an LSB of the divided result, used for round-half-up.
  function automatic int round_offset(input int log2_win);
    return (log2_win == 0) ? 0 : (1 << (log2_win - 1));
  endfunction

endpackage

// File: rtl/avg_channel_ring.sv
// One channel's ring buffer and running sum; o_result is the average after the pending update.
// Build option: MOVING_AVERAGE_ROUND_EN selects round-half-up instead of truncation.
module avg_channel_ring
  import moving_average_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int LOG2_WIN = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_upd,
  input  logic [LOG2_WIN-1:0] i_rp,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic [SAMPLE_W-1:0] o_result
);

  localparam int SUM_W  = sum_w_of(SAMPLE_W, LOG2_WIN);
  localparam int WINDOW = window_of(LOG2_WIN);

  logic [SAMPLE_W-1:0] r_ring [WINDOW];
  logic [SUM_W-1:0]    r_sum;
  logic [SUM_W-1:0]    w_sum_nxt;
  logic [SUM_W-1:0]    w_sum_adj;

  // The oldest sample is always contained in r_sum, so the subtraction never underflows.
  assign w_sum_nxt = r_sum + SUM_W'(i_sample) - SUM_W'(r_ring[i_rp]);

`ifdef MOVING_AVERAGE_ROUND_EN
  assign w_sum_adj = w_sum_nxt + SUM_W'(round_offset(LOG2_WIN));
`else
  assign w_sum_adj = w_sum_nxt;
`endif

  assign o_result = w_sum_adj[SUM_W-1 -: SAMPLE_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
      for (int i = 0; i < WINDOW; i++) r_ring[i] <= '0;
    end else if (i_upd) begin
      r_sum        <= w_sum_nxt;
      r_ring[i_rp] <= i_sample;
    end
  end

endmodule

// File: rtl/moving_average_multi.sv
// N-channel moving average with ADC clock generation and ping-pong output buffer sequencing.
// Build option: MOVING_AVERAGE_ROUND_EN (rounding inside avg_channel_ring).
module moving_average_multi
  import moving_average_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 8,
  parameter int LOG2_WIN = 2,
  parameter int ADDR_W   = 10,
  parameter int ADC_DIV  = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ENA,
  input  logic                         MODE,
  input  logic [CHANNELS*SAMPLE_W-1:0] ADC_DATA,
  output logic                         CLK_ADC,
  output logic [SAMPLE_W-1:0]          DATA_OUT,
  output logic [ADDR_W-1:0]            WADDR_OUT,
  output logic                         WENA_OUT,
  output logic [1:0]                   BUFREADY,
  input  logic [1:0]                   BUF_ACK,
  output logic                         OVERFLOW
);

  localparam int WINDOW     = window_of(LOG2_WIN);
  localparam int HALF_DEPTH = half_depth_of(ADDR_W);
  localparam int CNT_W      = (ADC_DIV > 1) ? $clog2(ADC_DIV) : 1;
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t                       r_state, w_state_nxt;
  logic [CNT_W-1:0]             r_cnt, w_cnt_nxt;
  logic                         r_clk_adc;
  logic [CHANNELS*SAMPLE_W-1:0] r_adc_p0;
  logic                         r_mode_p0;
  logic [CH_W-1:0]              r_ch;
  logic [LOG2_WIN-1:0]          r_rp;
  logic [ADDR_W-1:0]            r_wp;
  logic [SAMPLE_W-1:0]          w_res [CHANNELS];
  logic                         w_strobe, w_last_ch, w_wr_req, w_last_word;
  logic [1:0]                   w_set;

  assign w_cnt_nxt = (r_cnt == CNT_W'(ADC_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
  assign w_strobe  = ENA && (r_state == ST_WAIT) && (r_cnt == CNT_W'(ADC_DIV - 1));
  assign w_last_ch = (r_ch == CH_W'(CHANNELS - 1));
  assign CLK_ADC   = r_clk_adc;

  always_ff @(posedge CLK) begin
    if (RST || !ENA) begin
      r_cnt     <= '0;
      r_clk_adc <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_clk_adc <= (w_cnt_nxt < CNT_W'(ADC_DIV / 2));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (ENA) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!ENA)          w_state_nxt = ST_IDLE;
        else if (w_strobe) w_state_nxt = ST_PROC;
      end
      ST_PROC: if (w_last_ch) w_state_nxt = ENA ? ST_WAIT : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_rp      <= '0;
      r_mode_p0 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_strobe) begin
        r_mode_p0 <= MODE;
        r_ch      <= '0;
      end else if (r_state == ST_PROC) begin
        if (w_last_ch) begin
          r_ch <= '0;
          r_rp <= r_rp + LOG2_WIN'(1);
        end else begin
          r_ch <= r_ch + CH_W'(1);
        end
      end
    end
  end

  // Stage p0: all channels captured at the strobe.
  always_ff @(posedge CLK) begin
    if (w_strobe) r_adc_p0 <= ADC_DATA;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    avg_channel_ring #(
      .SAMPLE_W(SAMPLE_W),
      .LOG2_WIN(LOG2_WIN)
    ) u_ring (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_upd    ((r_state == ST_PROC) && (r_ch == CH_W'(g))),
      .i_rp     (r_rp),
      .i_sample (r_adc_p0[g*SAMPLE_W +: SAMPLE_W]),
      .o_result (w_res[g])
    );
  end

  assign w_wr_req    = (r_state == ST_PROC) && (!r_mode_p0 || (r_rp == LOG2_WIN'(WINDOW - 1)));
  assign w_last_word = (WADDR_OUT[ADDR_W-2:0] == (ADDR_W-1)'(HALF_DEPTH - 1));
  assign w_set       = {WENA_OUT && w_last_word && WADDR_OUT[ADDR_W-1],
                        WENA_OUT && w_last_word && !WADDR_OUT[ADDR_W-1]};

  // Stage p1: registered write to the output buffer; a full target half drops the word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_OUT  <= '0;
      WADDR_OUT <= '0;
      WENA_OUT  <= 1'b0;
      r_wp      <= '0;
      BUFREADY  <= 2'b00;
      OVERFLOW  <= 1'b0;
    end else begin
      WENA_OUT <= 1'b0;
      if (w_wr_req) begin
        if (BUFREADY[r_wp[ADDR_W-1]]) begin
          OVERFLOW <= 1'b1;
        end else begin
          WENA_OUT  <= 1'b1;
          DATA_OUT  <= w_res[r_ch];
          WADDR_OUT <= r_wp;
          r_wp      <= r_wp + ADDR_W'(1);
        end
      end
      BUFREADY <= (BUFREADY & ~BUF_ACK) | w_set;
    end
  end

endmodule

// File: tb/tb_moving_average_multi.sv
// Randomized bench for moving_average_multi against a queue-based window-average model.
module tb_moving_average_multi;

  localparam int CH    = 2;
  localparam int SW    = 8;
  localparam int LW    = 2;
  localparam int AW    = 4;
  localparam int DIV   = 8;
  localparam int WIN   = 1 << LW;
  localparam int HALF  = 1 << (AW - 1);
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic             ENA = 1'b0;
  logic             MODE = 1'b0;
  logic [CH*SW-1:0] ADC_DATA = '0;
  logic [1:0]       BUF_ACK = 2'b00;
  logic             CLK_ADC;
  logic [SW-1:0]    DATA_OUT;
  logic [AW-1:0]    WADDR_OUT;
  logic             WENA_OUT;
  logic [1:0]       BUFREADY;
  logic             OVERFLOW;

  always #5 clk = ~clk;

  moving_average_multi #(
    .CHANNELS(CH), .SAMPLE_W(SW), .LOG2_WIN(LW), .ADDR_W(AW), .ADC_DIV(DIV)
  ) dut (
    .CLK(clk), .RST(RST), .ENA(ENA), .MODE(MODE), .ADC_DATA(ADC_DATA),
    .CLK_ADC(CLK_ADC), .DATA_OUT(DATA_OUT), .WADDR_OUT(WADDR_OUT), .WENA_OUT(WENA_OUT),
    .BUFREADY(BUFREADY), .BUF_ACK(BUF_ACK), .OVERFLOW(OVERFLOW)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Reference model: sample history per channel, expected write list with due cycle.
  typedef struct { int due; int data; int addr; } wr_t;
  wr_t        expq[$];
  int         hist[CH][$];
  int         cyc = 0;
  int         m_cnt = 0;
  int         m_pass = 0;
  int         m_wp = 0;
  int         m_strobes = 0;
  logic [1:0] m_ready = 2'b00;
  logic       m_ovf = 1'b0;

  task automatic model_strobe();
    int avg[CH];
    int sum;
    m_pass++;
    m_strobes++;
    for (int c = 0; c < CH; c++) begin
      hist[c].push_back(int'(ADC_DATA[c*SW +: SW]));
      void'(hist[c].pop_front());
      sum = 0;
      for (int k = 0; k < hist[c].size(); k++) sum += hist[c][k];
`ifdef MOVING_AVERAGE_ROUND_EN
      avg[c] = (sum + WIN / 2) / WIN;
`else
      avg[c] = sum / WIN;
`endif
    end
    if (MODE == 1'b0 || (m_pass % WIN) == 0) begin
      for (int c = 0; c < CH; c++) begin
        int h;
        wr_t e;
        h = m_wp / HALF;
        if (m_ready[h]) begin
          m_ovf = 1'b1;
        end else begin
          e.due  = cyc + 1 + c;
          e.data = avg[c];
          e.addr = m_wp;
          expq.push_back(e);
          if ((m_wp % HALF) == HALF - 1) m_ready[h] = 1'b1;
          m_wp = (m_wp + 1) % DEPTH;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (RST) begin
      m_cnt = 0; m_pass = 0; m_wp = 0; m_ready = 2'b00; m_ovf = 1'b0;
      expq.delete();
      for (int c = 0; c < CH; c++) begin
        hist[c].delete();
        for (int k = 0; k < WIN; k++) hist[c].push_back(0);
      end
    end else begin
      m_ready = m_ready & ~BUF_ACK;
      if (ENA && m_cnt == DIV - 1) model_strobe();
      m_cnt = ENA ? (m_cnt + 1) % DIV : 0;
    end
  end

  // Write monitor: every WENA_OUT must match the next expected write, in its cycle.
  initial forever begin
    @(negedge clk);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      wr_t e;
      e = expq.pop_front();
      chk("wena", 32'(WENA_OUT), 32'd1);
      chk("data_out", 32'(DATA_OUT), 32'(e.data));
      chk("waddr_out", 32'(WADDR_OUT), 32'(e.addr));
    end else if (WENA_OUT) begin
      chk("wena_spurious", 32'd1, 32'd0);
    end
  end

  task automatic set_data(input int a, input int b);
    ADC_DATA = {SW'(b), SW'(a)};
  endtask

  task automatic run_strobes(input int n);
    int start, budget;
    start  = m_strobes;
    budget = (n + 4) * DIV;
    while ((m_strobes - start) < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if ((m_strobes - start) < n) chk("strobe_timeout", 32'(m_strobes - start), 32'(n));
  endtask

  task automatic wait_cnt(input int v);
    int budget;
    budget = 3 * DIV;
    do begin
      @(negedge clk);
      budget--;
    end while (m_cnt != v && budget > 0);
    if (m_cnt != v) chk("cnt_timeout", 32'(m_cnt), 32'(v));
  endtask

  task automatic do_reset();
    @(negedge clk);
    ENA = 1'b0;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_bufready"}, 32'(BUFREADY), 32'(m_ready));
    chk({tag, "_overflow"}, 32'(OVERFLOW), 32'(m_ovf));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk_adc", 32'(CLK_ADC), 32'd0);
    chk("rst_data_out", 32'(DATA_OUT), 32'd0);
    chk("rst_waddr", 32'(WADDR_OUT), 32'd0);
    chk("rst_wena", 32'(WENA_OUT), 32'd0);
    chk("rst_bufready", 32'(BUFREADY), 32'd0);
    chk("rst_overflow", 32'(OVERFLOW), 32'd0);
    RST = 1'b0;

    // Sliding mode, constant inputs.
    set_data(100, 200); MODE = 1'b0; ENA = 1'b1;
    run_strobes(6);
    wait_cnt(6);
    chk("t1_bufready", 32'(BUFREADY), 32'd1);
    check_flags("t1");

    // Block mode, constant inputs.
    do_reset();
    MODE = 1'b1; ENA = 1'b1;
    run_strobes(8);
    wait_cnt(6);
    check_flags("t2");

    // Fill both halves without acknowledge, then release half 0.
    do_reset();
    MODE = 1'b0; ENA = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_data(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      run_strobes(1);
    end
    wait_cnt(4);
    chk("t3_bufready_full", 32'(BUFREADY), 32'd3);
    chk("t3_overflow", 32'(OVERFLOW), 32'd1);
    BUF_ACK = 2'b01;
    @(negedge clk);
    BUF_ACK = 2'b00;
    chk("t3_bufready_ack", 32'(BUFREADY), 32'd2);
    run_strobes(1);
    wait_cnt(6);
    check_flags("t3");

    // Full-scale inputs.
    do_reset();
    set_data(255, 255); MODE = 1'b0; ENA = 1'b1;
    run_strobes(6);

    // Rounding sequence on channel 0.
    do_reset();
    ENA = 1'b1;
    set_data(0, 7);   run_strobes(1);
    set_data(0, 1);   run_strobes(1);
    set_data(0, 6);   run_strobes(1);
    set_data(2, 3);   run_strobes(1);
    wait_cnt(4);

    // ENA drop mid-pass, resume, then reset mid-pass.
    do_reset();
    set_data(100, 200); ENA = 1'b1;
    run_strobes(2);
    run_strobes(1);
    ENA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      chk("t6_clk_adc_idle", 32'(CLK_ADC), 32'd0);
    end
    ENA = 1'b1;
    run_strobes(3);
    run_strobes(1);
    RST = 1'b1;
    @(negedge clk);
    chk("t6_rst_data_out", 32'(DATA_OUT), 32'd0);
    chk("t6_rst_waddr", 32'(WADDR_OUT), 32'd0);
    chk("t6_rst_wena", 32'(WENA_OUT), 32'd0);
    chk("t6_rst_bufready", 32'(BUFREADY), 32'd0);
    chk("t6_rst_overflow", 32'(OVERFLOW), 32'd0);
    chk("t6_rst_clk_adc", 32'(CLK_ADC), 32'd0);
    RST = 1'b0;
    run_strobes(2);

    // Random data, random mode and random acknowledges.
    do_reset();
    ENA = 1'b1;
    for (int i = 0; i < 40; i++) begin
      MODE = 1'($urandom_range(0, 1));
      set_data(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      run_strobes(1);
      if ($urandom_range(0, 2) == 0) begin
        wait_cnt(4);
        BUF_ACK = 2'($urandom_range(0, 3));
        @(negedge clk);
        BUF_ACK = 2'b00;
      end
      wait_cnt(6);
      check_flags("t7");
    end

    ENA = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    chk("pending_writes", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/moving_average_multi.md
Name: moving_average_multi

Overview:
Parametrised successor of the two-ADC moving-average block. It supports N ADC channels, a power-of-two window, configurable sample width, and a run-time sliding/block (decimating) mode. The block generates the shared ADC sample clock and keeps a per-channel ring buffer and running sum. Averages are written sequentially into a ping-pong output buffer (USB-buffer style RAM), with per-half ready flags, acknowledge inputs and overflow detection.

Parameters:
CHANNELS, 2, number of ADC channels (1..8)
SAMPLE_W, 8, ADC sample and result width
LOG2_WIN, 2, log2 of window length; WINDOW = 2**LOG2_WIN
ADDR_W, 10, output buffer address width; each half holds 2**(ADDR_W-1) words
ADC_DIV, 8, CLK cycles per ADC sample; must be >= CHANNELS+3 and even

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous active-high reset
ENA  in  1  run enable
MODE  in  1  0 = sliding (one output per sample), 1 = block (one output per WINDOW samples)
ADC_DATA  in  CHANNELS*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W]
CLK_ADC  out  1  ADC sample clock
DATA_OUT  out  SAMPLE_W  averaged result
WADDR_OUT  out  ADDR_W  output buffer write address
WENA_OUT  out  1  output buffer write strobe, one cycle per word
BUFREADY  out  2  bit h set when half h is full
BUF_ACK  in  2  pulse bit h to release half h
OVERFLOW  out  1  sticky: a result was dropped

Behaviour:
- Reset values: CLK_ADC=0, DATA_OUT=0, WADDR_OUT=0, WENA_OUT=0, BUFREADY=00, OVERFLOW=0. Divider, ring pointer and write pointer are 0. All ring entries and sums are 0. FSM is IDLE.
- Divider: cnt runs 0..ADC_DIV-1 while ENA=1. CLK_ADC=1 for cnt < ADC_DIV/2, else 0. When ENA=0, cnt is held at 0 and CLK_ADC=0.
- Strobe: at cnt==ADC_DIV-1, all channels of ADC_DATA are latched in one cycle (cycle T).
- FSM states: IDLE -> WAIT (ENA=1) -> PROC (strobe) -> WAIT after the last channel; WAIT -> IDLE when ENA=0.
- ENA falling during PROC: the pass completes, then the FSM goes to IDLE. Ring and sums are kept. On re-enable, processing resumes at the stored pointers.
- PROC handles channel c at cycle T+1+c:
  - sum_c <= sum_c + new_c - ring_c[rp]
  - ring_c[rp] <= new_c
- rp is shared by all channels and increments mod WINDOW after the last channel.
- Result = sum_c >> LOG2_WIN, truncated. Sum width is SAMPLE_W+LOG2_WIN, so it never overflows.
- Before the window has filled, the ring is zero-prefilled and the division is still by WINDOW (ramp-up).
- Output is registered: channel c is written with WENA_OUT=1 at cycle T+2+c.
- Block mode: a write occurs only on the pass where rp==WINDOW-1 before the increment.
- Write addressing: WADDR_OUT = wp, and wp increments mod 2**ADDR_W after each write.
- Half boundary: when a write lands on the last word of half h, BUFREADY[h] is set on the next cycle.
- Overflow: if wp's half has BUFREADY set at write time, WENA_OUT stays 0, wp does not advance, and OVERFLOW is set (cleared only by RST). Averaging continues.
- BUF_ACK[h] clears BUFREADY[h]. If set and ack hit the same bit in the same cycle, set wins.
- A MODE change takes effect at the next strobe.
- RST mid-PROC: all state returns to reset values at the next edge, and any pending write is discarded.

Optional Feature:
Macro MOVING_AVERAGE_ROUND_EN.
- Defined: result = (sum_c + 2**(LOG2_WIN-1)) >> LOG2_WIN, i.e. round half up. The maximum value still fits SAMPLE_W+LOG2_WIN bits, so there is no saturation.
- Undefined: truncation as above, with no adder in the path.

Decomposition:
- Shared package moving_average_pkg holds:
  - FSM state encoding (IDLE, WAIT, PROC)
  - SUM_W = SAMPLE_W+LOG2_WIN
  - WINDOW and HALF_DEPTH localparams
  - the rounding-offset function
- Sub-module avg_channel_ring holds one channel's ring buffer and running sum with its update/result logic. It is instantiated CHANNELS times in a generate loop. The top module holds the divider, FSM, write sequencer and ping-pong flags.

Test Plan:
Default config is CHANNELS=2, SAMPLE_W=8, LOG2_WIN=2, ADDR_W=4, ADC_DIV=8.
1. Sliding mode, ch0=100, ch1=200 constant -> writes 25,50,50,100,75,150,100,200,100,200... at addresses 0,1,2,...; writes land at strobe+2 and strobe+3.
2. Block mode, same inputs -> only every 4th strobe writes: 100 at addr 0 and 200 at addr 1, then addr 2,3; no WENA_OUT on the other strobes.
3. Sliding mode, no BUF_ACK -> after 8 writes BUFREADY=01; after 16 writes BUFREADY=11; the 17th result is dropped with WENA_OUT=0, OVERFLOW=1 and wp=0. Pulse BUF_ACK=01 -> BUFREADY=10, and the next write goes to addr 0.
4. Both channels at 255 constant -> steady output 255, with no wrap in the sum.
5. Rounding: ch0 sequence 0,0,0,2 -> 4th result is 0 without the macro and 1 with MOVING_AVERAGE_ROUND_EN.
6. ENA low mid-PROC -> current pass writes both channels, then CLK_ADC stays 0. After re-enable, results continue without a ramp. RST mid-PROC -> all outputs return to reset values the next cycle and the ramp restarts at 25/50.
